// File: rtl/elink_rx_checker.sv
// Receive-side checker for an elink test run: compares incoming writes against an
// LFSR data stream and a linear address sequence, with optional periodic backpressure.
module elink_rx_checker #(
    parameter int unsigned NUM_TRANS  = 256,
    parameter logic [31:0] SEED       = 32'h1234_5678,
    parameter logic [31:0] ADDR_BASE  = 32'h8080_0000,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned WAIT_EVERY = 0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        rx_access,
    input  logic [31:0] rx_dstaddr,
    input  logic [31:0] rx_data,
    output logic        rx_wait,
    output logic        done,
    output logic        error,
    output logic        timeout,
    output logic [15:0] rx_count,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] idle_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] exp_addr;
    logic        accept;
    logic        mismatch;
    logic        last_trans;
    logic        stall_now;
    logic        idle_expired;

    always_comb begin
        accept       = (state == RUN) && rx_access && !rx_wait;
        exp_addr     = ADDR_BASE + {14'd0, rx_count, 2'b00};
        mismatch     = (rx_data != lfsr) || (rx_dstaddr != exp_addr);
        last_trans   = ({16'd0, rx_count} + 32'd1) == NUM_TRANS;
        stall_now    = (WAIT_EVERY != 0) && ((stall_cnt + 32'd1) == WAIT_EVERY);
        idle_expired = (idle_cnt + 32'd1) >= TIMEOUT;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            rx_wait   <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            timeout   <= 1'b0;
            rx_count  <= '0;
            err_count <= '0;
            lfsr      <= SEED;
            idle_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rx_wait <= 1'b1;
                    if (start) begin
                        state     <= RUN;
                        rx_wait   <= 1'b0;
                        lfsr      <= SEED;
                        rx_count  <= '0;
                        err_count <= '0;
                        error     <= 1'b0;
                        timeout   <= 1'b0;
                        idle_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        lfsr     <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
                        rx_count <= rx_count + 16'd1;
                        idle_cnt <= '0;
                        if (mismatch) begin
                            error <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + 16'd1;
                        end
                        // Completion takes priority over the stall slot.
                        if (last_trans) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            rx_wait <= 1'b1;
                        end else if (stall_now) begin
                            rx_wait   <= 1'b1;
                            stall_cnt <= '0;
                        end else begin
                            rx_wait   <= 1'b0;
                            stall_cnt <= stall_cnt + 32'd1;
                        end
                    end else begin
                        rx_wait <= 1'b0;
                        if (idle_expired) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            error   <= 1'b1;
                            timeout <= 1'b1;
                            rx_wait <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
                    end
                end
                DONE: begin
                    rx_wait <= 1'b1;
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elink_rx_checker.sv
// Randomized bench for elink_rx_checker: two instances (no stall / stall every 2,
// wrapping address base) checked every cycle against a transaction-level model.
module tb_elink_rx_checker;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic        rx_access;
    logic [31:0] rx_dstaddr;
    logic [31:0] rx_data;
    logic        sel;

    logic        w0, dn0, er0, to0, w1, dn1, er1, to1;
    logic [15:0] c0, ec0, c1, ec1;
    logic        o_wait, o_done, o_error, o_timeout;
    logic [15:0] o_count, o_errcnt;

    always #5 aclk = ~aclk;

    elink_rx_checker #(
        .NUM_TRANS(4), .TIMEOUT(16), .WAIT_EVERY(0)
    ) dut0 (
        .aclk(aclk), .aresetn(aresetn), .start(start & ~sel), .rx_access(rx_access & ~sel),
        .rx_dstaddr(rx_dstaddr), .rx_data(rx_data), .rx_wait(w0), .done(dn0),
        .error(er0), .timeout(to0), .rx_count(c0), .err_count(ec0)
    );

    elink_rx_checker #(
        .NUM_TRANS(10), .SEED(32'hDEAD_BEEF), .ADDR_BASE(32'hFFFF_FFF0),
        .TIMEOUT(16), .WAIT_EVERY(2)
    ) dut1 (
        .aclk(aclk), .aresetn(aresetn), .start(start & sel), .rx_access(rx_access & sel),
        .rx_dstaddr(rx_dstaddr), .rx_data(rx_data), .rx_wait(w1), .done(dn1),
        .error(er1), .timeout(to1), .rx_count(c1), .err_count(ec1)
    );

    assign o_wait    = sel ? w1  : w0;
    assign o_done    = sel ? dn1 : dn0;
    assign o_error   = sel ? er1 : er0;
    assign o_timeout = sel ? to1 : to0;
    assign o_count   = sel ? c1  : c0;
    assign o_errcnt  = sel ? ec1 : ec0;

    // Reference model: transaction-level view of the selected instance.
    int unsigned m_n, m_to, m_we, m_cnt, m_errcnt, m_idle;
    logic [31:0] m_seed, m_base, m_lfsr;
    bit          m_run, m_done, m_err, m_tout, m_wait;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    task automatic model_reset();
        m_run = 0; m_done = 0; m_err = 0; m_tout = 0; m_wait = 1;
        m_cnt = 0; m_errcnt = 0; m_idle = 0; m_lfsr = m_seed;
    endtask

    task automatic model_step(input bit s, input bit a, input logic [31:0] addr,
                              input logic [31:0] data);
        if (!m_run && !m_done) begin
            if (s) begin
                m_run = 1; m_lfsr = m_seed; m_cnt = 0; m_errcnt = 0;
                m_err = 0; m_tout = 0; m_idle = 0; m_wait = 0;
            end
        end else if (m_run) begin
            if (a && !m_wait) begin
                if (data != m_lfsr || addr != m_base + 4 * m_cnt) begin
                    m_err = 1;
                    if (m_errcnt < 16'hFFFF) m_errcnt++;
                end
                m_lfsr = lfsr_next(m_lfsr);
                m_cnt++;
                m_idle = 0;
                if (m_cnt == m_n) begin
                    m_run = 0; m_done = 1; m_wait = 1;
                end else begin
                    m_wait = (m_we != 0) && (m_cnt % m_we == 0);
                end
            end else begin
                m_idle++;
                m_wait = 0;
                if (m_idle == m_to) begin
                    m_run = 0; m_done = 1; m_err = 1; m_tout = 1; m_wait = 1;
                end
            end
        end else if (!s) begin
            m_done = 0;
        end
    endtask

    task automatic check_outputs();
        check("rx_wait",   o_wait,    m_wait);
        check("done",      o_done,    m_done);
        check("error",     o_error,   m_err);
        check("timeout",   o_timeout, m_tout);
        check("rx_count",  o_count,   m_cnt);
        check("err_count", o_errcnt,  m_errcnt);
    endtask

    task automatic tick(input bit s, input bit a, input logic [31:0] addr, input logic [31:0] data);
        @(negedge aclk);
        check_outputs();
        start = s; rx_access = a; rx_dstaddr = addr; rx_data = data;
        model_step(s, a, addr, data);
    endtask

    // Asserted away from the clock edge so the outputs must clear asynchronously.
    task automatic apply_reset();
        @(negedge aclk);
        aresetn = 0; start = 0; rx_access = 0;
        #1;
        model_reset();
        check("rst_wait",   o_wait,    1);
        check("rst_done",   o_done,    0);
        check("rst_error",  o_error,   0);
        check("rst_tout",   o_timeout, 0);
        check("rst_count",  o_count,   0);
        check("rst_errcnt", o_errcnt,  0);
        @(negedge aclk);
        aresetn = 1;
    endtask

    task automatic select(input bit s);
        sel = s;
        if (!s) begin
            m_n = 4;  m_to = 16; m_we = 0; m_seed = 32'h1234_5678; m_base = 32'h8080_0000;
        end else begin
            m_n = 10; m_to = 16; m_we = 2; m_seed = 32'hDEAD_BEEF; m_base = 32'hFFFF_FFF0;
        end
        apply_reset();
    endtask

    // bad_data/bad_addr: transaction index to corrupt (-1 none); stop_after: offers cease
    // once that many were accepted; abort_cyc: mid-run reset cycle (-1 none).
    task automatic run(input int bad_data, input int bad_addr, input int stop_after,
                       input int pct, input int abort_cyc, input bit chk,
                       input bit e_err, input int e_errcnt, input int e_cnt, input bit e_to);
        int cyc = 0;
        bit offer;
        logic [31:0] addr, data;
        tick(1, 0, '0, '0);
        while (m_run && cyc < 400) begin
            offer = (m_cnt < stop_after) && ($urandom_range(0, 99) < pct);
            addr  = m_base + 4 * m_cnt;
            data  = m_lfsr;
            if (int'(m_cnt) == bad_data) data = data ^ 32'h1;
            if (int'(m_cnt) == bad_addr) addr = addr + 32'h8;
            if (!offer) begin
                addr = $urandom; data = $urandom;
            end
            tick(1'($urandom_range(0, 1)), offer, addr, data);
            cyc++;
            if (cyc == abort_cyc) begin
                apply_reset();
                return;
            end
        end
        if (m_run) begin
            n_checks++; n_fail++;
            $display("FAIL run_budget: got %0d cycles required completion", cyc);
        end
        tick(1, 1, $urandom, $urandom);
        tick(1, 0, '0, '0);
        if (chk) begin
            check("end_done",   o_done,    1);
            check("end_error",  o_error,   e_err);
            check("end_errcnt", o_errcnt,  e_errcnt);
            check("end_count",  o_count,   e_cnt);
            check("end_tout",   o_timeout, e_to);
        end
        tick(0, 0, '0, '0);
        tick(0, 0, '0, '0);
        tick(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 0; start = 0; rx_access = 0; rx_dstaddr = '0; rx_data = '0; sel = 0;
        select(0);
        run(-1, -1, 99, 100, -1, 1, 0, 0, 4, 0);
        run(1, -1, 99, 70, -1, 1, 1, 1, 4, 0);
        run(-1, 2, 99, 70, -1, 1, 1, 1, 4, 0);
        run(-1, -1, 2, 100, -1, 1, 1, 0, 2, 1);
        run(-1, -1, 99, 60, -1, 1, 0, 0, 4, 0);

        select(1);
        run(-1, -1, 99, 100, -1, 1, 0, 0, 10, 0);
        run(-1, -1, 99, 100, 7, 0, 0, 0, 0, 0);
        run(-1, -1, 99, 80, -1, 1, 0, 0, 10, 0);
        run(3, 6, 99, 75, -1, 1, 1, 2, 10, 0);
        run(-1, -1, 5, 90, -1, 1, 1, 0, 5, 1);

        for (int i = 0; i < 6; i++) begin
            select(1'($urandom_range(0, 1)));
            run($urandom_range(0, 12) - 1, $urandom_range(0, 12) - 1,
                $urandom_range(1, 12), $urandom_range(40, 100), -1, 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
